// File: rtl/uart_fifo_pkg.sv
// Shared constants and helpers for the UART synchronous FIFO.
// Status-bit indices give the register-map packing of the FIFO flags.
package uart_fifo_pkg;

    localparam int unsigned FIFO_DATA_W_DEF = 9;
    localparam int unsigned FIFO_DEPTH_DEF  = 16;

    localparam int unsigned STAT_EMPTY      = 0;
    localparam int unsigned STAT_FULL       = 1;
    localparam int unsigned STAT_OV         = 2;
    localparam int unsigned STAT_UF         = 3;
    localparam int unsigned STAT_THRESH_HIT = 4;
    localparam int unsigned STAT_W          = 5;

    // Width able to hold 0..depth inclusive.
    function automatic int unsigned lvl_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [STAT_W-1:0] pack_status(
        input logic empty,
        input logic full,
        input logic ov,
        input logic uf,
        input logic thresh_hit
    );
        logic [STAT_W-1:0] s;
        s                  = '0;
        s[STAT_EMPTY]      = empty;
        s[STAT_FULL]       = full;
        s[STAT_OV]         = ov;
        s[STAT_UF]         = uf;
        s[STAT_THRESH_HIT] = thresh_hit;
        return s;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage for uart_sync_fifo: synchronous write,
// registered synchronous read. Only the read register is reset.
module uart_fifo_mem #(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write when addresses collide (full FIFO, simultaneous push/pop).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_sync_fifo.sv
// Parametrised synchronous FIFO for UART TX/RX paths with sticky ov/uf flags.
// Define UART_FIFO_THRESH_EN to enable the programmable fill-level thresh_hit flag.
module uart_sync_fifo
    import uart_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W_DEF,
    parameter int unsigned DEPTH  = FIFO_DEPTH_DEF,
    parameter int unsigned LVL_W  = lvl_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level,
    output logic              ov,
    output logic              uf,
    input  logic              clr_ov,
    input  logic              clr_uf,
    input  logic [LVL_W-1:0]  thresh,
    output logic              thresh_hit
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_accept;
    logic          rd_accept;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);

    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_accept);

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_accept, rd_accept})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Setting wins over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ov <= 1'b0;
            uf <= 1'b0;
        end else begin
            if (wr_en && full && !rd_accept) begin
                ov <= 1'b1;
            end else if (clr_ov) begin
                ov <= 1'b0;
            end
            if (rd_en && empty) begin
                uf <= 1'b1;
            end else if (clr_uf) begin
                uf <= 1'b0;
            end
        end
    end

`ifdef UART_FIFO_THRESH_EN
    assign thresh_hit = (level >= thresh) && (thresh != '0);
`else
    logic thresh_unused;
    assign thresh_unused = ^thresh;
    assign thresh_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Scoreboard bench for uart_sync_fifo at default parameters (DATA_W=9, DEPTH=16).
// thresh_hit expectations follow UART_FIFO_THRESH_EN as compiled.
module tb_uart_sync_fifo;
    import uart_fifo_pkg::*;

    localparam int unsigned DW  = 9;
    localparam int unsigned DEP = 16;
    localparam int unsigned LW  = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          ov;
    logic          uf;
    logic          clr_ov;
    logic          clr_uf;
    logic [LW-1:0] thresh;
    logic          thresh_hit;

    uart_sync_fifo #(
        .DATA_W (DW),
        .DEPTH  (DEP),
        .LVL_W  (LW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .ov         (ov),
        .uf         (uf),
        .clr_ov     (clr_ov),
        .clr_uf     (clr_uf),
        .thresh     (thresh),
        .thresh_hit (thresh_hit)
    );

    always #5 clk = ~clk;

    int unsigned   vectors     = 0;
    int unsigned   miscompares = 0;
    logic [DW-1:0] sb[$];
    int unsigned   mlvl;
    logic          mov;
    logic          muf;
    logic [DW-1:0] last_pop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_thresh_hit();
`ifdef UART_FIFO_THRESH_EN
        return (thresh != '0) && (mlvl >= 32'(thresh));
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outputs(input logic exp_valid);
        check("rd_valid",   32'(rd_valid),   32'(exp_valid));
        check("rd_data",    32'(rd_data),    32'(last_pop));
        check("level",      32'(level),      mlvl);
        check("full",       32'(full),       32'(mlvl == DEP));
        check("empty",      32'(empty),      32'(mlvl == 0));
        check("ov",         32'(ov),         32'(mov));
        check("uf",         32'(uf),         32'(muf));
        check("thresh_hit", 32'(thresh_hit), 32'(exp_thresh_hit()));
    endtask

    // One clock of stimulus; model is updated from the pre-edge state.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                        input logic cov = 1'b0, input logic cuf = 1'b0);
        logic m_rd;
        logic m_wr;
        logic m_full;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr_ov  = cov;
        clr_uf  = cuf;
        m_full  = (mlvl == DEP);
        m_rd    = r && (mlvl != 0);
        m_wr    = w && (!m_full || m_rd);
        if (w && m_full && !m_rd) mov = 1'b1;
        else if (cov)             mov = 1'b0;
        if (r && mlvl == 0)       muf = 1'b1;
        else if (cuf)             muf = 1'b0;
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        clr_ov = 1'b0;
        clr_uf = 1'b0;
        if (m_rd && sb.size() != 0) last_pop = sb.pop_front();
        if (m_wr) sb.push_back(d);
        if (m_wr && !m_rd)      mlvl++;
        else if (m_rd && !m_wr) mlvl--;
        check_outputs(m_rd);
    endtask

    task automatic model_reset();
        sb.delete();
        mlvl     = 0;
        mov      = 1'b0;
        muf      = 1'b0;
        last_pop = '0;
    endtask

    // Assert reset mid-cycle, check the asynchronous clear, release on a negedge.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        model_reset();
        check_outputs(1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        clr_ov  = 1'b0;
        clr_uf  = 1'b0;
        thresh  = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Basic write/read ordering
        step(1'b1, 9'h1A5, 1'b0);
        step(1'b1, 9'h0FF, 1'b0);
        step(1'b1, 9'h100, 1'b0);
        check("lvl_after_3_writes", 32'(level), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        check("last_word_100", 32'(rd_data), 32'h100);
        step(1'b0, '0, 1'b0);

        // Overflow: fill, rejected write, contents intact, clear
        for (int i = 0; i < 16; i++) step(1'b1, DW'(9'h120 + i), 1'b0);
        step(1'b1, 9'h055, 1'b0);
        check("ov_set_on_full_write", 32'(ov), 32'd1);
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
        check("drained_last_is_12f", 32'(rd_data), 32'h12F);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("ov_cleared", 32'(ov), 32'd0);

        // Full with simultaneous push/pop
        for (int i = 0; i < 16; i++) step(1'b1, DW'(9'h040 + i), 1'b0);
        step(1'b1, 9'h0AA, 1'b1);
        check("full_rw_no_ov", 32'(ov), 32'd0);
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
        check("full_rw_last_aa", 32'(rd_data), 32'h0AA);

        // Empty with simultaneous push/pop: no bypass, underflow flagged
        step(1'b1, 9'h033, 1'b1);
        check("empty_rw_uf", 32'(uf), 32'd1);
        step(1'b0, '0, 1'b1);
        check("empty_rw_readback", 32'(rd_data), 32'h033);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("uf_set_beats_clear", 32'(uf), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Pointer wrap with interleaved single-entry traffic
        for (int i = 0; i < 40; i++) begin
            step(1'b1, DW'(i + 9'h080), 1'b0);
            check("wrap_lvl_max", 32'(level <= 5'd1), 32'd1);
            step(1'b0, '0, 1'b1);
        end

        // Threshold flag
        thresh = 5'd4;
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, DW'(9'h1C0 + i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        thresh = 5'd0;
        for (int i = 0; i < 12; i++) step(1'b1, DW'(9'h010 + i), 1'b0);
        thresh = 5'd16;
        step(1'b1, 9'h1FF, 1'b0);
        step(1'b0, '0, 1'b1);

        // Asynchronous reset mid-operation, then immediate reuse
        do_reset();
        step(1'b1, 9'h15A, 1'b0);
        step(1'b0, '0, 1'b1);
        check("post_reset_readback", 32'(rd_data), 32'h15A);
        for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
